// File: rtl/sound_arbiter.sv
// sound_arbiter: shares one piezo between alarm, keypad beep and lullaby (alarm > beep > lullaby),
// inserting a silent gap on every change of owner.
module sound_arbiter #(
   parameter logic [12:0] BEEP_CODE = 13'd3822,
   parameter int          BEEP_LEN  = 10,
   parameter int          GAP_LEN   = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        tick,
   input  logic        alarm_active,
   input  logic [12:0] alarm_beat,
   input  logic        lullaby_active,
   input  logic [12:0] lullaby_beat,
   input  logic        key_pulse,
   input  logic        mute,
   output logic [12:0] playSound,
   output logic [1:0]  owner,
   output logic        gap,
   output logic        beep_done
);
   localparam logic [2:0]  S_IDLE   = 3'd0;
   localparam logic [2:0]  S_LULL   = 3'd1;
   localparam logic [2:0]  S_BEEP   = 3'd2;
   localparam logic [2:0]  S_ALARM  = 3'd3;
   localparam logic [2:0]  S_GAP    = 3'd4;
   localparam logic [15:0] BEEP_END = 16'(BEEP_LEN - 1);
   localparam logic [15:0] GAP_END  = 16'(GAP_LEN - 1);
   localparam bit          NO_GAP   = (GAP_LEN == 0);

   logic [2:0]  r_state, w_next, r_target, w_tgt, w_pick;
   logic        r_tick_q, r_pend;
   logic [15:0] r_beep_cnt, r_gap_cnt;
   logic        w_tick_en, w_beep_req, w_lull_req, w_beep_end, w_gap_end;
   logic        w_leave, w_reload, w_done;
   logic [12:0] w_play;
   logic [1:0]  w_owner;

   assign w_tick_en  = tick & ~r_tick_q;
   assign w_beep_req = key_pulse & ~mute;
   assign w_lull_req = lullaby_active & ~mute;
   assign w_beep_end = w_tick_en && r_beep_cnt == BEEP_END;
   assign w_gap_end  = w_tick_en && r_gap_cnt == GAP_END;
   // inside a gap, a beep survives from the latched target or a press seen during the gap
   assign w_pick = alarm_active ? S_ALARM :
      (w_beep_req || (r_state == S_GAP && !mute && (r_target == S_BEEP || r_pend))) ? S_BEEP :
      w_lull_req ? S_LULL : S_IDLE;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_target   <= S_IDLE;
         r_tick_q   <= 1'b0;
         r_pend     <= 1'b0;
         r_beep_cnt <= '0;
         r_gap_cnt  <= '0;
         playSound  <= '0;
         owner      <= '0;
         gap        <= 1'b0;
         beep_done  <= 1'b0;
      end else begin
         r_tick_q   <= tick;
         r_state    <= w_next;
         r_target   <= (r_state != S_GAP) ? w_tgt : alarm_active ? S_ALARM : r_target;
         r_pend     <= r_state == S_GAP && w_next == S_GAP && (r_pend || (w_beep_req && !alarm_active));
         r_gap_cnt  <= (w_next != r_state) ? '0 : (r_state == S_GAP && w_tick_en) ? r_gap_cnt + 16'd1 : r_gap_cnt;
         r_beep_cnt <= (w_next != r_state || w_reload) ? '0 :
                       (r_state == S_BEEP && w_tick_en) ? r_beep_cnt + 16'd1 : r_beep_cnt;
         playSound  <= w_play;
         owner      <= w_owner;
         gap        <= r_state == S_GAP;
         beep_done  <= w_done;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_tgt    = S_IDLE;
      w_leave  = 1'b0;
      w_reload = 1'b0;
      w_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tgt   = w_pick;
            w_leave = w_pick != S_IDLE;
         end
         S_LULL: begin
            w_tgt   = alarm_active ? S_ALARM : S_BEEP;
            w_leave = alarm_active | w_beep_req;
            if (!w_leave && !w_lull_req) w_next = S_IDLE;
         end
         S_BEEP: begin
            w_tgt    = alarm_active ? S_ALARM : S_IDLE;
            w_reload = !alarm_active && !mute && key_pulse;
            w_done   = !alarm_active && !mute && !key_pulse && w_beep_end;
            w_leave  = alarm_active | w_done;
            if (!alarm_active && mute) w_next = S_IDLE;
         end
         S_ALARM: w_leave = !alarm_active;
         S_GAP:   if (w_gap_end) w_next = w_pick;
         default: w_next = S_IDLE;
      endcase
      // a target of IDLE means "re-evaluate requests when the gap is over"
      if (w_leave) w_next = NO_GAP ? (w_tgt == S_IDLE ? w_pick : w_tgt) : S_GAP;
   end

   always_comb begin
      w_play  = r_state == S_LULL ? lullaby_beat : r_state == S_BEEP ? BEEP_CODE :
                r_state == S_ALARM ? alarm_beat : 13'd0;
      w_owner = r_state[1:0];
   end
endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed and random stimulus against a countdown-based reference model,
// expected outputs queued per cycle and checked by an independent monitor.
module tb_sound_arbiter;
   localparam logic [12:0] BEEP_CODE = 13'd3822;
   localparam int          BEEP_LEN  = 10;
   localparam int          GAP_LEN   = 3;

   logic        clock = 0, reset = 1, tick = 0;
   logic        alarm_active = 0, lullaby_active = 0, key_pulse = 0, mute = 0;
   logic [12:0] alarm_beat = 0, lullaby_beat = 0;
   logic [12:0] playSound;
   logic [1:0]  owner;
   logic        gap, beep_done;

   sound_arbiter #(.BEEP_CODE(BEEP_CODE), .BEEP_LEN(BEEP_LEN), .GAP_LEN(GAP_LEN)) dut (
      .clock(clock), .reset(reset), .tick(tick),
      .alarm_active(alarm_active), .alarm_beat(alarm_beat),
      .lullaby_active(lullaby_active), .lullaby_beat(lullaby_beat),
      .key_pulse(key_pulse), .mute(mute),
      .playSound(playSound), .owner(owner), .gap(gap), .beep_done(beep_done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [12:0] play;
      logic [1:0]  own;
      logic        g;
      logic        d;
   } exp_t;
   typedef enum int {QUIET, LULL, BEEP, ALARM, GAP} mode_t;

   exp_t  q[$];
   exp_t  got;
   int    checks = 0, passed = 0, done_seen = 0, tcnt = 0;
   bit    rand_tick = 0;
   mode_t m_mode = QUIET;
   bit    m_prev = 0, m_tgt_beep = 0, m_pend = 0;
   int    m_gap_left = 0, m_beep_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // monitor: one comparison per DUT output cycle, decoupled from the driver
   always @(posedge clock) begin
      #1;
      if (!reset) begin
         if (beep_done) done_seen++;
         if (q.size() != 0) begin
            got = q.pop_front();
            checks++;
            if ({playSound, owner, gap, beep_done} === got) passed++;
            else $display("FAIL out @%0t: got play=%0d own=%0d gap=%0b done=%0b expected play=%0d own=%0d gap=%0b done=%0b",
                          $time, playSound, owner, gap, beep_done, got.play, got.own, got.g, got.d);
         end
      end
   end

   task automatic start_gap(input bit want_beep);
      m_mode = GAP;
      m_tgt_beep = want_beep;
      m_pend = 0;
      m_gap_left = GAP_LEN;
   endtask

   task automatic become(input mode_t m);
      if (m == BEEP) m_beep_left = BEEP_LEN;
      m_mode = m;
   endtask

   // reference model: evaluated with the inputs that the next rising edge will sample
   task automatic model_step();
      exp_t  e;
      bit    tk;
      mode_t p;
      e.play = m_mode == LULL ? lullaby_beat : m_mode == BEEP ? BEEP_CODE : m_mode == ALARM ? alarm_beat : 13'd0;
      e.own  = m_mode == LULL ? 2'd1 : m_mode == BEEP ? 2'd2 : m_mode == ALARM ? 2'd3 : 2'd0;
      e.g    = m_mode == GAP;
      e.d    = 0;
      tk = tick && !m_prev;
      m_prev = tick;
      case (m_mode)
         QUIET: begin
            p = alarm_active ? ALARM : (key_pulse && !mute) ? BEEP : (lullaby_active && !mute) ? LULL : QUIET;
            if (p != QUIET) start_gap(p == BEEP);
         end
         LULL:
            if (alarm_active) start_gap(0);
            else if (key_pulse && !mute) start_gap(1);
            else if (!lullaby_active || mute) m_mode = QUIET;
         BEEP:
            if (alarm_active) start_gap(0);
            else if (mute) m_mode = QUIET;
            else if (key_pulse) m_beep_left = BEEP_LEN;
            else if (tk) begin
               m_beep_left--;
               if (m_beep_left == 0) begin
                  e.d = 1;
                  start_gap(0);
               end
            end
         ALARM: if (!alarm_active) start_gap(0);
         default: begin
            if (alarm_active) m_tgt_beep = 0;
            else if (key_pulse && !mute) m_pend = 1;
            if (tk) begin
               m_gap_left--;
               if (m_gap_left == 0)
                  become(alarm_active ? ALARM : (!mute && (m_tgt_beep || m_pend)) ? BEEP :
                         (lullaby_active && !mute) ? LULL : QUIET);
            end
         end
      endcase
      q.push_back(e);
   endtask

   task automatic model_reset();
      m_mode = QUIET;
      m_prev = 0;
      m_tgt_beep = 0;
      m_pend = 0;
      m_gap_left = 0;
      m_beep_left = 0;
   endtask

   // called at a falling edge; leaves at the next falling edge
   task automatic step(input bit k);
      if (rand_tick) tick = $urandom_range(0, 3) == 0;
      else begin
         tick = tcnt == 0;
         tcnt = (tcnt + 1) % 4;
      end
      key_pulse = k;
      model_step();
      @(negedge clock);
   endtask

   task automatic run(input int n);
      repeat (n) step(0);
   endtask

   task automatic async_reset();
      check("pre_reset_play", playSound, BEEP_CODE);
      tick = 0;
      #2 reset = 1;
      #1;
      check("async_reset_play", playSound, 0);
      check("async_reset_owner", owner, 0);
      check("async_reset_done", beep_done, 0);
      q.delete();
      @(negedge clock);
      @(negedge clock);
      check("held_reset_owner", owner, 0);
      reset = 0;
      model_reset();
   endtask

   initial begin
      #7;
      check("reset_play", playSound, 0);
      check("reset_owner", owner, 0);
      check("reset_gap", gap, 0);
      check("reset_done", beep_done, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 0;
      model_reset();
      // lullaby alone, then a beep over it
      lullaby_active = 1;
      lullaby_beat = 13'd2000;
      run(30);
      check("lullaby_owner", owner, 1);
      check("lullaby_play", playSound, 2000);
      step(1);
      run(80);
      lullaby_beat = 13'd0;
      run(8);
      check("rest_keeps_owner", owner, 1);
      lullaby_beat = 13'd2200;
      run(4);
      // alarm preempts a beep in progress
      lullaby_active = 0;
      run(20);
      done_seen = 0;
      step(1);
      run(28);
      alarm_active = 1;
      alarm_beat = 13'd3000;
      run(30);
      check("alarm_owner", owner, 3);
      check("preempt_no_done", done_seen, 0);
      alarm_active = 0;
      run(30);
      // mute blocks beep and lullaby but not alarm
      mute = 1;
      lullaby_active = 1;
      step(1);
      run(20);
      check("mute_owner", owner, 0);
      alarm_active = 1;
      alarm_beat = 13'd1500;
      step(1);
      run(30);
      check("mute_alarm_play", playSound, 1500);
      alarm_active = 0;
      mute = 0;
      lullaby_active = 0;
      run(30);
      // retrigger at beep tick 8
      done_seen = 0;
      step(1);
      run(44);
      step(1);
      run(90);
      check("retrigger_one_done", done_seen, 1);
      // asynchronous reset mid-beep
      step(1);
      run(30);
      async_reset();
      run(10);
      check("post_reset_owner", owner, 0);
      // random traffic, including multi-cycle ticks
      rand_tick = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 149) == 0) alarm_active = ~alarm_active;
         if ($urandom_range(0, 99) == 0) lullaby_active = ~lullaby_active;
         if ($urandom_range(0, 199) == 0) mute = ~mute;
         if ($urandom_range(0, 7) == 0) alarm_beat = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom);
         if ($urandom_range(0, 7) == 0) lullaby_beat = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom);
         step($urandom_range(0, 39) == 0);
      end
      @(posedge clock);
      #2;
      check("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
